// File: rtl/shift_pkg.sv
// Shared types and step sizes for the multi-cycle shift sequencer.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_RSV = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } seq_state_e;

  localparam int unsigned STEP_BIG   = 3;
  localparam int unsigned STEP_SMALL = 1;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle; slave is the sequencer side, master the requester/consumer side.
interface shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             busy;

  modport slave (
    input  in_valid, in_data, in_op, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_err, busy
  );

  modport master (
    output in_valid, in_data, in_op, in_amt, out_ready,
    input  in_ready, out_valid, out_data, out_err, busy
  );

endinterface

// File: rtl/shift_step.sv
// Combinational fixed-step shifter: moves the value by 3 or 1 in the direction the op selects.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  shift_op_e        op_i,
  input  logic             big_i,
  output logic [WIDTH-1:0] val_o
);

  always_comb begin
    val_o = val_i;
    case (op_i)
      SH_SLL:  val_o = big_i ? (val_i << STEP_BIG) : (val_i << STEP_SMALL);
      SH_SRL:  val_o = big_i ? (val_i >> STEP_BIG) : (val_i >> STEP_SMALL);
      // Refill from the current MSB each step so the sign survives every iteration.
      SH_SRA:  val_o = big_i ? ($signed(val_i) >>> STEP_BIG) : ($signed(val_i) >>> STEP_SMALL);
      default: val_o = val_i;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative 32-bit shifter: floor(amt/3)+(amt%3) steps, result one cycle after the last step.
// One request in flight; the result holds in DONE until out_ready, in_ready low meanwhile.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  io
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  shift_op_e        op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] step_out;
  logic             big_step;

  assign big_step = (rem_q >= AMT_W'(STEP_BIG));

  shift_step #(.WIDTH(WIDTH)) u_step (
    .val_i (data_q),
    .op_i  (op_q),
    .big_i (big_step),
    .val_o (step_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          op_d    = shift_op_e'(io.in_op);
          data_d  = io.in_data;
          err_d   = (op_d == SH_RSV);
          // Reserved op skips the datapath entirely and reports an error.
          rem_d   = err_d ? '0 : io.in_amt;
          state_d = (rem_d != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        data_d = step_out;
        rem_d  = rem_q - (big_step ? AMT_W'(STEP_BIG) : AMT_W'(STEP_SMALL));
        if (rem_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= SH_SLL;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Outputs are masked outside DONE so intermediate step values never leak.
  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.out_data  = (state_q == DONE) ? data_q : '0;
  assign io.out_err   = (state_q == DONE) && err_q;
  assign io.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and random transactions against an arithmetic reference of the shift rules.
module tb_shift_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_data;
  logic        exp_err;
  int          exp_lat;

  shift_sequencer_if #(.WIDTH(32), .AMT_W(5)) sif ();

  shift_sequencer #(.WIDTH(32), .AMT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .io  (sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: whole-amount shift in one go, latency from the step-count formula.
  task automatic set_exp(input logic [31:0] d, input logic [1:0] op, input logic [4:0] amt);
    int a;
    a = int'(amt);
    case (op)
      2'b00:   exp_data = d << a;
      2'b01:   exp_data = d >> a;
      2'b10:   exp_data = $signed(d) >>> a;
      default: exp_data = d;
    endcase
    exp_err = (op == 2'b11);
    exp_lat = (op == 2'b11 || a == 0) ? 1 : (a / 3 + a % 3 + 1);
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] op, input logic [4:0] amt);
    int w;
    w = 0;
    while (!sif.in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("accept_ready", 32'(sif.in_ready), 32'd1);
    set_exp(d, op, amt);
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    sif.in_op    = op;
    sif.in_amt   = amt;
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
  endtask

  // Called in the first cycle after the accept edge; scrambles inputs while waiting.
  task automatic wait_result(input string tag);
    int lat;
    lat = 1;
    while (!sif.out_valid && lat < 40) begin
      sif.in_valid = 1'($urandom_range(0, 1));
      sif.in_data  = $urandom;
      sif.in_op    = 2'($urandom);
      sif.in_amt   = 5'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    sif.in_valid = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, sif.out_data, exp_data);
    chk({tag, "_err"}, 32'(sif.out_err), 32'(exp_err));
    chk({tag, "_busy"}, 32'(sif.busy), 32'd1);
    chk({tag, "_in_ready_low"}, 32'(sif.in_ready), 32'd0);
  endtask

  task automatic release_out(input string tag);
    sif.out_ready = 1'b1;
    @(posedge clk); #1;
    sif.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(sif.out_valid), 32'd0);
    chk({tag, "_ready_rise"}, 32'(sif.in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(sif.in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(sif.out_valid), 32'd0);
    chk({tag, "_out_data"}, sif.out_data, 32'd0);
    chk({tag, "_out_err"}, 32'(sif.out_err), 32'd0);
    chk({tag, "_busy"}, 32'(sif.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.in_op     = '0;
    sif.in_amt    = '0;
    sif.out_ready = 1'b0;

    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("post_reset_idle");

    send(32'h8000_0000, 2'b10, 5'd3);  wait_result("sra3");    release_out("sra3");
    send(32'h0000_0001, 2'b00, 5'd31); wait_result("sll31");   release_out("sll31");
    send(32'h8000_0000, 2'b10, 5'd31); wait_result("sra31");   release_out("sra31");
    send(32'hFFFF_FFFF, 2'b01, 5'd5);  wait_result("srl5");    release_out("srl5");
    send(32'hDEAD_BEEF, 2'b00, 5'd0);  wait_result("sll0");    release_out("sll0");
    send(32'hDEAD_BEEF, 2'b10, 5'd0);  wait_result("sra0");    release_out("sra0");
    send(32'h1234_5678, 2'b11, 5'd7);  wait_result("rsv");     release_out("rsv");
    send(32'h7FFF_FFFF, 2'b10, 5'd2);  wait_result("sra_pos"); release_out("sra_pos");

    // Backpressure: result must hold while a new request waits.
    send(32'hFFFF_FFFF, 2'b01, 5'd5);
    wait_result("bp");
    held = sif.out_data;
    sif.in_valid = 1'b1;
    sif.in_data  = 32'h0000_ABCD;
    sif.in_op    = 2'b00;
    sif.in_amt   = 5'd4;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid_hold", 32'(sif.out_valid), 32'd1);
      chk("bp_data_hold", sif.out_data, held);
      chk("bp_in_ready_low", 32'(sif.in_ready), 32'd0);
    end
    release_out("bp");
    set_exp(32'h0000_ABCD, 2'b00, 5'd4);
    @(posedge clk); #1;
    sif.in_valid = 1'b0;
    wait_result("bp_next");
    release_out("bp_next");

    // Reset in the fourth cycle of a long shift.
    send(32'h0000_0001, 2'b00, 5'd31);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    check_reset_outputs("mid_reset_hold");
    #2 rst = 1'b0;
    @(posedge clk); #1;
    send(32'h0000_00F0, 2'b01, 5'd4); wait_result("after_rst"); release_out("after_rst");

    for (int n = 0; n < 40; n++) begin
      logic [31:0] d;
      logic [1:0]  op;
      logic [4:0]  amt;
      d   = $urandom;
      op  = 2'($urandom_range(0, 3));
      amt = 5'($urandom_range(0, 31));
      send(d, op, amt);
      wait_result("rand");
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      chk("rand_data_stable", sif.out_data, exp_data);
      release_out("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
